// File: rtl/psum_gatherer.sv
// Gathers one partial sum from each PE column, then drains them in column order
// onto a valid/ready bus with a last flag and an end-of-pass pulse.
module psum_gatherer #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned NUM_COL    = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          gth_en,
    input  logic [NUM_COL-1:0]            pe_valid,
    input  logic [NUM_COL*2*DATA_WIDTH-1:0] pe_psum,
    output logic [NUM_COL-1:0]            pe_ready,
    output logic                          gth_valid,
    output logic [2*DATA_WIDTH-1:0]       gth_data,
    output logic [$clog2(NUM_COL)-1:0]    gth_col,
    output logic                          gth_last,
    input  logic                          gth_ready,
    output logic                          gth_busy,
    output logic                          gth_done
);

    localparam int unsigned PW = 2 * DATA_WIDTH;
    localparam int unsigned IW = $clog2(NUM_COL);
    localparam logic [IW-1:0] LastIdx = IW'(NUM_COL - 1);

    typedef enum logic [1:0] {StIdle, StCollect, StDrain, StDone} state_e;

    state_e               state_q, state_d;
    logic [NUM_COL-1:0]   captured_q, captured_d;
    logic [IW-1:0]        idx_q, idx_d;
    logic [PW-1:0]        buf_q [NUM_COL];
    logic [PW-1:0]        buf_d [NUM_COL];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            captured_q <= '0;
            idx_q      <= '0;
            for (int unsigned i = 0; i < NUM_COL; i++) begin
                buf_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            captured_q <= captured_d;
            idx_q      <= idx_d;
            for (int unsigned i = 0; i < NUM_COL; i++) begin
                buf_q[i] <= buf_d[i];
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        captured_d = captured_q;
        idx_d      = idx_q;
        buf_d      = buf_q;
        pe_ready   = '0;
        gth_valid  = 1'b0;
        gth_data   = '0;
        gth_col    = '0;
        gth_last   = 1'b0;
        gth_busy   = 1'b1;
        gth_done   = 1'b0;

        case (state_q)
            StIdle: begin
                gth_busy = 1'b0;
                if (gth_en) begin
                    state_d    = StCollect;
                    captured_d = '0;
                    idx_d      = '0;
                end
            end
            StCollect: begin
                pe_ready = ~captured_q;
                // Several columns may land in the same cycle; each is latched only once.
                for (int unsigned i = 0; i < NUM_COL; i++) begin
                    if (pe_valid[i] && !captured_q[i]) begin
                        buf_d[i]      = pe_psum[i*PW +: PW];
                        captured_d[i] = 1'b1;
                    end
                end
                if (&captured_d) begin
                    state_d = StDrain;
                end
            end
            StDrain: begin
                gth_valid = 1'b1;
                gth_data  = buf_q[idx_q];
                gth_col   = idx_q;
                gth_last  = (idx_q == LastIdx);
                if (gth_ready) begin
                    if (idx_q == LastIdx) begin
                        idx_d   = '0;
                        state_d = StDone;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            StDone: begin
                gth_done = 1'b1;
                state_d  = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // Outputs are held quiet for the whole reset window, even before the first edge.
        if (rst) begin
            pe_ready  = '0;
            gth_valid = 1'b0;
            gth_data  = '0;
            gth_col   = '0;
            gth_last  = 1'b0;
            gth_busy  = 1'b0;
            gth_done  = 1'b0;
        end
    end

endmodule

// File: doc/psum_gatherer.md
PSUM_GATHERER -- requirements
Module: psum_gatherer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16, PE operand width; psum width PW = 2*DATA_WIDTH.
REQ-002 SHALL have parameter NUM_COL, default 4, number of PE columns gathered (>=2).
REQ-003 SHALL have port clk  input  1  sole clock; all logic on rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port gth_en  input  1  start one gather pass (sampled in IDLE only).
REQ-006 SHALL have port pe_valid  input  NUM_COL  per-column psum valid from PE.
REQ-007 SHALL have port pe_psum  input  NUM_COL*PW  flattened psums; column i at bits [i*PW +: PW].
REQ-008 SHALL have port pe_ready  output  NUM_COL  per-column accept to PE.
REQ-009 SHALL have port gth_valid  output  1  psum word available to bus.
REQ-010 SHALL have port gth_data  output  PW  psum word to bus.
REQ-011 SHALL have port gth_col  output  $clog2(NUM_COL)  column index of gth_data.
REQ-012 SHALL have port gth_last  output  1  high with gth_valid on final column.
REQ-013 SHALL have port gth_ready  input  1  bus accepts word.
REQ-014 SHALL have port gth_busy  output  1  high in any state other than IDLE.
REQ-015 SHALL have port gth_done  output  1  one-cycle pulse at pass end.

Function
REQ-016 SHALL implement FSM states IDLE, COLLECT, DRAIN, DONE.
REQ-017 IDLE: gth_en=1 -> COLLECT next cycle, clearing captured[NUM_COL-1:0] and drain index idx to 0; gth_en=0 -> stay.
REQ-018 COLLECT: pe_ready[i] = ~captured[i]; pe_valid[i]&pe_ready[i] -> buf[i]<=psum slice i, captured[i]<=1.
REQ-019 COLLECT: captures from multiple columns in the same cycle SHALL all be accepted.
REQ-020 COLLECT -> DRAIN the cycle after captured is all ones, including when the last capture(s) occur in the same cycle as others.
REQ-021 pe_ready SHALL be 0 in IDLE, DRAIN, DONE; pe_valid then ignored; a column SHALL never be captured twice per pass.
REQ-022 DRAIN: gth_valid=1, gth_data=buf[idx], gth_col=idx, gth_last=(idx==NUM_COL-1).
REQ-023 DRAIN: gth_valid&gth_ready -> idx+1; on gth_last handshake -> DONE, idx wraps to 0.
REQ-024 DRAIN: gth_ready=0 SHALL hold gth_data, gth_col, gth_last stable; gth_valid SHALL not drop before handshake.
REQ-025 DONE: gth_done=1 for exactly one cycle -> IDLE.
REQ-026 gth_valid, gth_last SHALL be 0 outside DRAIN; gth_data, gth_col SHALL be 0 outside DRAIN.
REQ-027 gth_en SHALL be ignored outside IDLE; no pass is queued.
REQ-028 Latency: final capture at cycle t -> gth_valid=1 at t+1; with gth_ready held 1, gth_done at t+NUM_COL+1.
REQ-029 Psum data SHALL pass unmodified (no arithmetic, no truncation), PW bits.

Reset
REQ-030 rst=1 at any clock edge, including mid-COLLECT or mid-DRAIN, SHALL force IDLE, captured=0, idx=0, and buf=0.
REQ-031 During and after reset all outputs SHALL be 0 (pe_ready, gth_valid, gth_data, gth_col, gth_last, gth_busy, gth_done).
REQ-032 rst SHALL take priority over gth_en and all handshakes in the same cycle.

Verification
REQ-033 In-order: gth_en pulse; pe_valid=4'b1111 with psums 0x00000011,0x00000022,0x00000033,0x00000044; gth_ready=1 -> next cycle DRAIN; words 0x11,0x22,0x33,0x44 with gth_col 0..3, gth_last on col 3; gth_done one cycle later.
REQ-034 Staggered: columns valid at cycles 3,1,4,2 after start -> each pe_ready drops after own capture; DRAIN begins cycle after col 2 captured; order still col 0..3.
REQ-035 Backpressure: gth_ready=0 for 5 cycles at idx=1 -> gth_data=buf[1], gth_col=1 held stable, no skip; resumes on gth_ready=1.
REQ-036 Re-capture guard: col 0 pe_valid held high during COLLECT with changing data 0xAAAA then 0xBBBB -> only 0xAAAA drained.
REQ-037 Reset mid-DRAIN at idx=2 -> next cycle all outputs 0, IDLE; new gth_en pass drains fresh data starting at col 0.
REQ-038 gth_en pulses during COLLECT/DRAIN -> exactly one gth_done per accepted start; gth_busy high from start+1 through DONE.
